// File: rtl/barramento_pkg.sv
// Shared defaults, width helper and FIFO entry layout for the multi-channel bus.
// Optional stored parity is enabled by defining BARRAMENTO_PARITY_EN.
package barramento_pkg;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_N_CH   = 4;
    localparam int DEF_DEPTH  = 8;

    function automatic int bw_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Entry layout at the default widths; the top re-declares it with its own parameters.
    typedef struct packed {
        logic [$clog2(DEF_N_CH)-1:0] ch_id;
`ifdef BARRAMENTO_PARITY_EN
        logic                        parity;
`endif
        logic [DEF_DATA_W-1:0]       data;
    } bar_entry_t;

endpackage

// File: rtl/barramento_rr_arb.sv
// Combinational round-robin arbiter: the first valid channel at or after rr_ptr wins.
module barramento_rr_arb
    import barramento_pkg::*;
#(
    parameter  int N_CH = DEF_N_CH,
    localparam int CH_W = bw_clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_valid,
    input  logic [CH_W-1:0] i_rr_ptr,
    input  logic            i_en,
    output logic [N_CH-1:0] o_gnt,
    output logic [CH_W-1:0] o_gnt_id
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N_CH; k++) begin
            w_idx = int'(i_rr_ptr) + k;
            if (w_idx >= N_CH) w_idx = w_idx - N_CH;
            if (!w_found && i_valid[w_idx]) begin
                w_found  = 1'b1;
                o_gnt_id = CH_W'(w_idx);
                o_gnt[w_idx] = i_en;
            end
        end
    end

endmodule

// File: rtl/barramento_mux_fifo.sv
// N_CH-to-1 ready/valid merge with round-robin arbitration into a shared FWFT FIFO.
// Define BARRAMENTO_PARITY_EN to add a stored per-word parity bit and parity_out.
module barramento_mux_fifo
    import barramento_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int N_CH   = DEF_N_CH,
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int CH_W   = bw_clog2(N_CH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_CH*DATA_W-1:0] ch_data_in,
    input  logic [N_CH-1:0]        ch_valid_in,
    output logic [N_CH-1:0]        ch_ready_out,
    output logic [DATA_W-1:0]      data_out,
    output logic [CH_W-1:0]        ch_id_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [CNT_W-1:0]       fill_level
`ifdef BARRAMENTO_PARITY_EN
    ,
    output logic                   parity_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [CH_W-1:0]   ch_id;
`ifdef BARRAMENTO_PARITY_EN
        logic              parity;
`endif
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CH_W-1:0]  r_rr_ptr;

    logic [N_CH-1:0]  w_gnt;
    logic [CH_W-1:0]  w_gnt_id;
    logic             w_en, w_push, w_pop, w_valid;
    entry_t           w_entry, w_head;

    // Ready is withheld while reset is asserted so no handshake can complete then.
    assign w_en = reset && (r_count != CNT_W'(DEPTH));

    barramento_rr_arb #(.N_CH(N_CH)) u_arb (
        .i_valid  (ch_valid_in),
        .i_rr_ptr (r_rr_ptr),
        .i_en     (w_en),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id)
    );

    assign ch_ready_out = w_gnt;
    assign w_push       = |(ch_valid_in & w_gnt);
    assign w_valid      = (r_count != '0);
    assign w_pop        = w_valid && ready_in;

    always_comb begin
        w_entry       = '0;
        w_entry.ch_id = w_gnt_id;
        w_entry.data  = ch_data_in[int'(w_gnt_id)*DATA_W +: DATA_W];
`ifdef BARRAMENTO_PARITY_EN
        w_entry.parity = ^w_entry.data;
`endif
    end

    // Storage carries no reset: stale words are unreachable once count is cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_rr_ptr <= (w_gnt_id == CH_W'(N_CH - 1)) ? '0 : w_gnt_id + CH_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign valid_out  = w_valid;
    assign data_out   = w_valid ? w_head.data  : '0;
    assign ch_id_out  = w_valid ? w_head.ch_id : '0;
    assign fill_level = r_count;
`ifdef BARRAMENTO_PARITY_EN
    assign parity_out = w_valid ? w_head.parity : 1'b0;
`endif

endmodule

// File: tb/tb_barramento_mux_fifo.sv
// Self-checking bench: directed steps plus random traffic against a queue-based model.
module tb_barramento_mux_fifo;

    localparam int DW = 128, NC = 4, DP = 8, CW = 2, CNTW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [NC*DW-1:0] ch_data_in;
    logic [NC-1:0]    ch_valid_in, ch_ready_out;
    logic [DW-1:0]    data_out;
    logic [CW-1:0]    ch_id_out;
    logic             valid_out, ready_in;
    logic [CNTW-1:0]  fill_level;
`ifdef BARRAMENTO_PARITY_EN
    logic             parity_out;
`endif

    barramento_mux_fifo dut (
        .clk(clk), .reset(reset), .ch_data_in(ch_data_in), .ch_valid_in(ch_valid_in),
        .ch_ready_out(ch_ready_out), .data_out(data_out), .ch_id_out(ch_id_out),
        .valid_out(valid_out), .ready_in(ready_in), .fill_level(fill_level)
`ifdef BARRAMENTO_PARITY_EN
        , .parity_out(parity_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int id; logic [DW-1:0] d; } ent_t;
    ent_t mq[$];
    int   mrr = 0;
    int   total = 0, bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Channel granted this cycle according to the arbitration rules, or -1.
    function automatic int exp_gnt();
        if (reset !== 1'b1 || mq.size() >= DP) return -1;
        for (int k = 0; k < NC; k++) begin
            int c = (mrr + k) % NC;
            if (ch_valid_in[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_out();
        int g = exp_gnt();
        logic [NC-1:0] er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("ready", DW'(ch_ready_out), DW'(er));
        chk("valid", DW'(valid_out), DW'(mq.size() != 0));
        chk("fill", DW'(fill_level), DW'(mq.size()));
        if (mq.size() != 0) begin
            chk("data", data_out, mq[0].d);
            chk("id", DW'(ch_id_out), DW'(mq[0].id));
`ifdef BARRAMENTO_PARITY_EN
            chk("parity", DW'(parity_out), DW'(^mq[0].d));
`endif
        end else begin
            chk("data_empty", data_out, '0);
            chk("id_empty", DW'(ch_id_out), '0);
`ifdef BARRAMENTO_PARITY_EN
            chk("parity_empty", DW'(parity_out), '0);
`endif
        end
    endtask

    // Check at negedge, advance the model at posedge, return 1 time unit after the edge.
    task automatic cycle();
        int g;
        bit pop;
        logic [DW-1:0] d;
        @(negedge clk);
        check_out();
        g   = exp_gnt();
        pop = (reset === 1'b1) && (mq.size() != 0) && ready_in;
        d   = (g >= 0) ? ch_data_in[g*DW +: DW] : '0;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (g >= 0) begin
            mq.push_back('{g, d});
            mrr = (g + 1) % NC;
        end
        #1;
    endtask

    task automatic setch(input int c, input logic [DW-1:0] d);
        ch_data_in[c*DW +: DW] = d;
    endtask

    function automatic logic [DW-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        reset = 1'b1; ch_data_in = '0; ch_valid_in = '0; ready_in = 1'b0;
        #1 reset = 1'b0;
        // 1: reset state, then a single word with 1-cycle latency
        cycle(); cycle();
        reset = 1'b1;
        setch(0, 128'h1234567890ABCDEF1234567890ABCDEF);
        ch_valid_in = 4'b0001; ready_in = 1'b1;
        cycle();
        chk("t1_data", data_out, 128'h1234567890ABCDEF1234567890ABCDEF);
        chk("t1_id", DW'(ch_id_out), '0);
        ch_valid_in = '0;
        cycle(); cycle();
        chk("t1_fill0", DW'(fill_level), '0);

        // 2: round robin across all channels
        setch(0, {16{8'h11}}); setch(1, {16{8'h22}});
        setch(2, {16{8'h33}}); setch(3, {16{8'h44}});
        ch_valid_in = 4'b1111;
        repeat (8) cycle();
        ch_valid_in = '0;
        repeat (3) cycle();

        // 3: fill to DEPTH under backpressure, then drain
        ready_in = 1'b0; setch(1, {16{8'h55}}); ch_valid_in = 4'b0010;
        repeat (10) cycle();
        chk("t3_fill8", DW'(fill_level), DW'(8));
        chk("t3_rdy0", DW'(ch_ready_out), '0);
        ch_valid_in = '0; ready_in = 1'b1;
        repeat (9) cycle();

        // 4: steady push+pop at fill 3 wraps the pointers
        ready_in = 1'b0; ch_valid_in = 4'b0100;
        repeat (3) begin setch(2, rnd()); cycle(); end
        ready_in = 1'b1;
        repeat (10) begin
            setch(2, rnd()); cycle();
            chk("t4_fill3", DW'(fill_level), DW'(3));
        end
        ch_valid_in = '0;
        repeat (4) cycle();

        // 5: asynchronous reset between edges with 5 words stored
        ready_in = 1'b0; ch_valid_in = 4'b0001;
        repeat (5) begin setch(0, rnd()); cycle(); end
        ch_valid_in = '0;
        chk("t5_fill5", DW'(fill_level), DW'(5));
        #2 reset = 1'b0;
        #1;
        chk("t5_valid", DW'(valid_out), '0);
        chk("t5_data", data_out, '0);
        chk("t5_fill", DW'(fill_level), '0);
        mq.delete(); mrr = 0;
        cycle();
        reset = 1'b1;
        setch(0, 128'hFEDCBA0987654321FEDCBA0987654321); ch_valid_in = 4'b0001;
        cycle();
        ch_valid_in = '0;
        chk("t5_fill1", DW'(fill_level), DW'(1));
        chk("t5_word", data_out, 128'hFEDCBA0987654321FEDCBA0987654321);
        ready_in = 1'b1;
        cycle(); cycle();

`ifdef BARRAMENTO_PARITY_EN
        // 6: parity stored with each word
        setch(0, 128'h1); ch_valid_in = 4'b0001;
        cycle();
        chk("t6_par1", DW'(parity_out), DW'(1));
        setch(0, 128'h3);
        cycle();
        chk("t6_par0", DW'(parity_out), '0);
        ch_valid_in = '0;
        cycle(); cycle();
`endif

        // random traffic
        repeat (400) begin
            ch_valid_in = NC'($urandom);
            for (int c = 0; c < NC; c++) setch(c, rnd());
            ready_in = ($urandom_range(0, 3) != 0);
            cycle();
        end
        ch_valid_in = '0; ready_in = 1'b1;
        repeat (10) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
